// File: rtl/uart_transceiver_if.sv
// rtl/uart_transceiver_if.sv - user-side TX/RX handshake bundle for uart_transceiver
interface uart_transceiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - parametrised full-duplex UART with optional parity, 1/2 stop bits and RX FIFO
module uart_transceiver #(
  parameter int DELAY_FRAMES  = 234,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  output logic               uart_tx,
  uart_transceiver_if.slave  io
);
  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_BIT    = CW'(DELAY_FRAMES);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DELAY_FRAMES / 2);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] LAST_BIT   = IW'(DATA_BITS - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_FONE   = (AW + 1)'(1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(RX_FIFO_DEPTH);
  localparam logic          HAS_PARITY = 1'(PARITY_MODE != 0);
  localparam logic          ODD        = 1'(PARITY_MODE == 2);
  localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_stop_idx;
  logic                 tx_line;
  logic                 tx_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_stop_idx <= 1'b0;
      tx_line     <= 1'b1;
      tx_rdy      <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      if (io.tx_valid && tx_rdy) begin
        tx_shift <= io.tx_data;
        tx_par   <= (^io.tx_data) ^ ODD;
        tx_line  <= 1'b0;
        tx_cnt   <= CNT_ONE;
        tx_rdy   <= 1'b0;
        tx_state <= S_START;
      end else begin
        tx_line <= 1'b1;
        tx_rdy  <= 1'b1;
      end
    end else if (tx_cnt != CNT_BIT) begin
      tx_cnt <= tx_cnt + CNT_ONE;
    end else begin
      tx_cnt <= CNT_ONE;
      case (tx_state)
        S_START: begin
          tx_line  <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_idx   <= '0;
          tx_state <= S_DATA;
        end
        S_DATA: begin
          if (tx_idx == LAST_BIT) begin
            tx_line     <= HAS_PARITY ? tx_par : 1'b1;
            tx_stop_idx <= 1'b0;
            tx_state    <= HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= tx_idx + IDX_ONE;
          end
        end
        S_PARITY: begin
          tx_line     <= 1'b1;
          tx_stop_idx <= 1'b0;
          tx_state    <= S_STOP;
        end
        S_STOP: begin
          if (tx_stop_idx == LAST_STOP) begin
            tx_state <= S_IDLE;
            tx_rdy   <= 1'b1;
          end else begin
            tx_stop_idx <= 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic                 rx_s1;
  logic                 rx_s2;
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 push;
  logic [EW-1:0]        push_entry;

  // Only the first stop bit is sampled; a second stop bit is just idle line to the receiver.
  assign push       = (rx_state == S_STOP) && (rx_cnt == CNT_BIT);
  assign push_entry = {rx_shift, ~rx_s2, HAS_PARITY & (rx_par_bit ^ (^rx_shift) ^ ODD)};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= CNT_ONE;
          end
        end
        S_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= CNT_ONE;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: begin
          if (rx_cnt != CNT_BIT) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else begin
            rx_cnt <= CNT_ONE;
            case (rx_state)
              S_DATA: begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == LAST_BIT) rx_state <= HAS_PARITY ? S_PARITY : S_STOP;
                else                    rx_idx   <= rx_idx + IDX_ONE;
              end
              S_PARITY: begin
                rx_par_bit <= rx_s2;
                rx_state   <= S_STOP;
              end
              default: rx_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  logic [EW-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          rx_vld;
  logic          ovr;
  logic          pop;
  logic          full;
  logic          accept;

  assign pop    = rx_vld && io.rx_ready;
  assign full   = (count == FIFO_FULL);
  // A same-cycle pop frees the head slot, so a full FIFO can still take the frame.
  assign accept = push && (!full || pop);

  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + CNT_FONE;
    else if (!accept && pop) count_next = count - CNT_FONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rx_vld <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_next;
      rx_vld <= (count_next != '0);
      ovr    <= push && full && !pop;
    end
  end

  assign uart_tx       = tx_line;
  assign io.tx_ready   = tx_rdy;
  assign io.rx_valid   = rx_vld;
  assign io.rx_overrun = ovr;
  assign {io.rx_data, io.rx_frame_err, io.rx_parity_err} = mem[rd_ptr];
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed bench: 8N1 TX, 7E2 loopback, parity/framing/glitch, overrun, mid-frame reset
module tb_uart_transceiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_a, rx_c;
  logic tx_a, tx_b, tx_c;
  int   errors = 0;
  int   checks = 0;
  int   ovr_cnt = 0;

  uart_transceiver_if #(.DATA_BITS(8)) ifa ();
  uart_transceiver_if #(.DATA_BITS(7)) ifb ();
  uart_transceiver_if #(.DATA_BITS(8)) ifc ();

  uart_transceiver #(.DELAY_FRAMES(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a), .uart_tx(tx_a), .io(ifa));
  uart_transceiver #(.DELAY_FRAMES(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(tx_b), .uart_tx(tx_b), .io(ifb));
  uart_transceiver #(.DELAY_FRAMES(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_c), .uart_tx(tx_c), .io(ifc));

  always @(negedge clk) if (ifa.rx_overrun === 1'b1) ovr_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic valid_of(input int which);
    if (which == 0) return ifa.rx_valid;
    if (which == 1) return ifb.rx_valid;
    return ifc.rx_valid;
  endfunction

  task automatic wait_valid(input int which, input int limit, input string tag);
    int n = 0;
    while (n < limit && valid_of(which) !== 1'b1) begin
      tick;
      n++;
    end
    check(tag, 32'(valid_of(which)), 32'd1);
  endtask

  task automatic pop(input int which);
    if (which == 0) ifa.rx_ready = 1'b1;
    else if (which == 1) ifb.rx_ready = 1'b1;
    else ifc.rx_ready = 1'b1;
    tick;
    ifa.rx_ready = 1'b0;
    ifb.rx_ready = 1'b0;
    ifc.rx_ready = 1'b0;
  endtask

  // Drives n bits (LSB first), 16 cycles each; pulses ifa.rx_ready after edge pop_at when pop_at > 0.
  task automatic drive_frame(input int which, input logic [15:0] bits, input int n, input int pop_at);
    int k = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (which == 0) rx_a = bits[b];
        else rx_c = bits[b];
        tick;
        k++;
        ifa.rx_ready = (k == pop_at);
      end
    end
    ifa.rx_ready = 1'b0;
    rx_a = 1'b1;
    rx_c = 1'b1;
  endtask

  logic [9:0]  frame;
  logic [15:0] fb;
  int          o0;

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_c = 1'b1;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0; ifa.rx_ready = 1'b0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0; ifb.rx_ready = 1'b0;
    ifc.tx_valid = 1'b0; ifc.tx_data = '0; ifc.rx_ready = 1'b0;
    repeat (3) tick;

    check("rst_uart_tx", 32'(tx_a), 32'd1);
    check("rst_tx_ready", 32'(ifa.tx_ready), 32'd0);
    check("rst_rx_valid", 32'(ifa.rx_valid), 32'd0);
    check("rst_rx_data", 32'(ifa.rx_data), 32'd0);
    check("rst_frame_err", 32'(ifa.rx_frame_err), 32'd0);
    check("rst_parity_err", 32'(ifa.rx_parity_err), 32'd0);
    check("rst_overrun", 32'(ifa.rx_overrun), 32'd0);
    rst_n = 1'b1;
    tick;
    check("ready_after_reset", 32'(ifa.tx_ready), 32'd1);

    // 8N1 transmit of 0x46; tx_data is scrambled after acceptance.
    frame = {1'b1, 8'h46, 1'b0};
    ifa.tx_data = 8'h46;
    ifa.tx_valid = 1'b1;
    for (int e = 0; e < 160; e++) begin
      tick;
      if (e == 0) begin
        ifa.tx_valid = 1'b0;
        ifa.tx_data = 8'hFF;
      end
      check("tx46_line", 32'(tx_a), 32'(frame[e/16]));
      if (e == 159) check("tx46_busy_160", 32'(ifa.tx_ready), 32'd0);
    end
    tick;
    check("tx46_ready_161", 32'(ifa.tx_ready), 32'd1);
    check("tx46_idle_line", 32'(tx_a), 32'd1);

    // 7E2 loopback: 0x55 then 0x7F back-to-back with tx_valid held.
    ifb.tx_data = 7'h55;
    ifb.tx_valid = 1'b1;
    for (int e = 0; e < 178; e++) begin
      tick;
      if (e == 0) ifb.tx_data = 7'h7F;
      if (e == 136) check("lb_parity_bit", 32'(tx_b), 32'd0);
      if (e == 170) begin
        check("lb55_valid", 32'(ifb.rx_valid), 32'd1);
        check("lb55_data", 32'(ifb.rx_data), 32'h55);
        check("lb55_frame_err", 32'(ifb.rx_frame_err), 32'd0);
        check("lb55_parity_err", 32'(ifb.rx_parity_err), 32'd0);
        ifb.rx_ready = 1'b1;
      end
      if (e == 171) ifb.rx_ready = 1'b0;
      if (e == 175) begin
        check("lb_stop2_line", 32'(tx_b), 32'd1);
        check("lb_stop2_busy", 32'(ifb.tx_ready), 32'd0);
      end
      if (e == 176) begin
        check("lb_gap_line", 32'(tx_b), 32'd1);
        check("lb_gap_ready", 32'(ifb.tx_ready), 32'd1);
      end
      if (e == 177) begin
        check("lb_second_start", 32'(tx_b), 32'd0);
        check("lb_second_busy", 32'(ifb.tx_ready), 32'd0);
        ifb.tx_valid = 1'b0;
      end
    end
    wait_valid(1, 300, "lb7f_valid");
    check("lb7f_data", 32'(ifb.rx_data), 32'h7F);
    check("lb7f_frame_err", 32'(ifb.rx_frame_err), 32'd0);
    check("lb7f_parity_err", 32'(ifb.rx_parity_err), 32'd0);
    pop(1);
    check("lb_empty", 32'(ifb.rx_valid), 32'd0);

    // Even-parity receiver, 0xA5 with a wrong parity bit of 1.
    drive_frame(2, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1);
    wait_valid(2, 40, "par_valid");
    check("par_data", 32'(ifc.rx_data), 32'hA5);
    check("par_parity_err", 32'(ifc.rx_parity_err), 32'd1);
    check("par_frame_err", 32'(ifc.rx_frame_err), 32'd0);
    pop(2);
    check("par_empty", 32'(ifc.rx_valid), 32'd0);

    // 0x3C with a low stop bit.
    drive_frame(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, -1);
    wait_valid(0, 40, "fr_valid");
    check("fr_data", 32'(ifa.rx_data), 32'h3C);
    check("fr_frame_err", 32'(ifa.rx_frame_err), 32'd1);
    check("fr_parity_err", 32'(ifa.rx_parity_err), 32'd0);
    pop(0);
    repeat (30) tick;
    check("fr_single_entry", 32'(ifa.rx_valid), 32'd0);

    // 4-cycle glitch must be rejected as a false start.
    rx_a = 1'b0;
    repeat (4) tick;
    rx_a = 1'b1;
    repeat (40) tick;
    check("glitch_no_push", 32'(ifa.rx_valid), 32'd0);

    // Overrun: five frames into a 4-deep FIFO with no pops.
    o0 = ovr_cnt;
    for (int d = 1; d <= 4; d++) begin
      fb = {7'b0, 1'b1, 8'(d), 1'b0};
      drive_frame(0, fb, 10, -1);
    end
    repeat (3) tick;
    check("ovr_none_at_4", 32'(ovr_cnt - o0), 32'd0);
    check("ovr_full_valid", 32'(ifa.rx_valid), 32'd1);
    fb = {7'b0, 1'b1, 8'h05, 1'b0};
    drive_frame(0, fb, 10, -1);
    repeat (3) tick;
    check("ovr_one_pulse", 32'(ovr_cnt - o0), 32'd1);
    for (int d = 1; d <= 4; d++) begin
      check("ovr_pop_data", 32'(ifa.rx_data), 32'(d));
      pop(0);
    end
    check("ovr_drained", 32'(ifa.rx_valid), 32'd0);

    // Full FIFO with a pop on the push edge: frame accepted, no overrun.
    for (int d = 17; d <= 20; d++) begin
      fb = {7'b0, 1'b1, 8'(d), 1'b0};
      drive_frame(0, fb, 10, -1);
    end
    o0 = ovr_cnt;
    fb = {7'b0, 1'b1, 8'h15, 1'b0};
    drive_frame(0, fb, 10, 154);
    repeat (3) tick;
    check("fullpop_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    for (int d = 18; d <= 21; d++) begin
      check("fullpop_data", 32'(ifa.rx_data), 32'(d));
      pop(0);
    end
    check("fullpop_drained", 32'(ifa.rx_valid), 32'd0);

    // Reset during data bit 3 of 0xFF, then a clean 0xA3 frame.
    ifa.tx_data = 8'hFF;
    ifa.tx_valid = 1'b1;
    for (int e = 0; e < 71; e++) begin
      tick;
      if (e == 0) ifa.tx_valid = 1'b0;
    end
    check("mid_tx_busy", 32'(ifa.tx_ready), 32'd0);
    rst_n = 1'b0;
    tick;
    check("mid_rst_uart_tx", 32'(tx_a), 32'd1);
    check("mid_rst_tx_ready", 32'(ifa.tx_ready), 32'd0);
    rst_n = 1'b1;
    tick;
    check("mid_release_ready", 32'(ifa.tx_ready), 32'd1);
    frame = {1'b1, 8'hA3, 1'b0};
    ifa.tx_data = 8'hA3;
    ifa.tx_valid = 1'b1;
    for (int e = 0; e < 160; e++) begin
      tick;
      if (e == 0) ifa.tx_valid = 1'b0;
      if (e % 16 == 8) check("post_rst_bit", 32'(tx_a), 32'(frame[e/16]));
    end
    tick;
    check("post_rst_ready", 32'(ifa.tx_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
